int_arbiter: RTL and testbench
==============================

Name: int_arbiter

Overview:
Multi-source interrupt controller in front of the CPU's single-line interrupt unit.
- Synchronises N peripheral interrupt lines and latches their rising edges as pending bits.
- Applies a mask and a global enable, then picks the highest-priority source (lowest index) and drives a single int_req toward the CPU INT input.
- Tracks the acknowledge / eret handshake, so only one interrupt is in service at a time (no nesting).
- Software reads and writes its state through a small 4-register config port.

Parameters:
N_SRC, 8, number of interrupt sources (2..32)
ID_W, 3, width of source id; must equal clog2(N_SRC)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
irq_in  in  N_SRC  raw peripheral interrupt levels, asynchronous to clk
cfg_we  in  1  config register write strobe
cfg_addr  in  2  config register index
cfg_wdata  in  32  config write data
cfg_rdata  out  32  config read data, combinational on cfg_addr
int_req  out  1  registered interrupt request to CPU INT
int_id  out  ID_W  id of requested / in-service source
int_ack  in  1  CPU accepted the request (one-cycle pulse)
eret  in  1  CPU returned from handler (one-cycle pulse)
int_busy  out  1  high while a source is in service

Behaviour:
Config registers:
- addr0 MASK: RW, bit i enables source i.
- addr1 PENDING: read returns pending bits; write-1-to-clear.
- addr2 CAUSE: RO; bit31 = valid, [ID_W-1:0] = in-service id.
- addr3 CTRL: bit0 = global enable (GEN), RW.
- Unused bits read 0.

Reset values:
- MASK, PENDING, CAUSE, GEN, sync flops = 0.
- int_req = 0, int_id = 0, int_busy = 0, FSM in IDLE.
- Reset applied mid-operation aborts any request or service immediately.

Synchronisation and edge capture:
- Per source: 2-flop synchroniser s1→s2, plus history flop s3.
- rise = s2 & ~s3.
- PENDING[i] is set at the edge where rise[i] is registered: visible 3 clk edges after irq_in[i] is first sampled high.
- A source held high across reset release produces exactly one pending set.
- A level held high produces no repeat sets.

Eligibility:
- elig = PENDING & MASK & {N{GEN}}, computed from registered values only.
- A cfg write takes effect for selection from the following cycle.

FSM:
- IDLE: if |elig, then at the next edge go to REQ, latch int_id = lowest set index of elig, and set int_req = 1. int_req rises one cycle after PENDING is visible.
- REQ: int_req and int_id stay stable; a new higher-priority pending does not preempt.
  - int_ack → SERVICE: clear PENDING[int_id], int_req = 0, CAUSE = {1, int_id}, int_busy = 1.
  - Withdrawal: if no ack and the selected source becomes ineligible (W1C clear, mask bit cleared, or GEN = 0), go to IDLE with int_req = 0.
- SERVICE: int_busy = 1; new edges keep accumulating in PENDING.
  - eret → IDLE: int_busy = 0, CAUSE.valid = 0.
  - At the following edge IDLE may issue the next request (1 idle cycle minimum between eret and the next int_req).

Ignored inputs and collisions:
- int_ack outside REQ is ignored.
- eret outside SERVICE is ignored.
- int_ack and a withdrawal condition in the same cycle: ack wins.
- W1C and a new rise on the same bit in the same cycle: set wins.
- Ack-clear of PENDING[id] and a new rise on the same bit in the same cycle: set wins, so the bit stays pending and is re-requested after eret.

Widths:
- PENDING and MASK writes use cfg_wdata[N_SRC-1:0]; upper bits are ignored.
- int_id is zero-extended into CAUSE.

Decomposition:
- Shared package int_arbiter_pkg holds:
  - register address constants: ADDR_MASK = 0, ADDR_PEND = 1, ADDR_CAUSE = 2, ADDR_CTRL = 3;
  - FSM state encoding: IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2;
  - the CAUSE valid bit position (31).
- One sub-module, int_prio_enc: parameterised combinational lowest-index-first priority encoder (input vector → any, id).
- Synchroniser, FSM and registers stay in int_arbiter.

Test Plan:
- MASK = 0xFF, GEN = 1; pulse irq_in[5] high → PENDING = 0x20 after 3 edges, int_req = 1 and int_id = 5 one cycle later; int_ack → int_req = 0, int_busy = 1, CAUSE = 0x80000005, PENDING = 0.
- irq_in[2] and irq_in[6] rise in the same cycle with MASK = 0xFF → int_id = 2 first; after ack and eret, int_id = 6 requested one cycle after IDLE.
- In REQ for id 3, write MASK = 0xF7 → int_req drops next cycle, PENDING[3] stays 1, FSM in IDLE; restore MASK = 0xFF → re-request with id 3.
- In REQ for id 4, write PENDING = 0x10 (W1C) in the same cycle as int_ack → ack wins: SERVICE, CAUSE = 0x80000004.
- During SERVICE of id 1, irq_in[0] rises → no int_req until eret; after eret, int_req with int_id = 0. eret in IDLE → no state change.
- Assert reset while in SERVICE with PENDING = 0x0C → all outputs and registers read 0; after release, an irq_in[7] held high sets PENDING = 0x80 exactly once.

Source files
------------

// File: rtl/int_arbiter_pkg.sv
// int_arbiter_pkg
// Shared definitions for the interrupt arbiter: config register addresses,
// the arbitration FSM state encoding and the CAUSE register layout.
package int_arbiter_pkg;

  // Config register indices on cfg_addr
  localparam logic [1:0] ADDR_MASK  = 2'd0;
  localparam logic [1:0] ADDR_PEND  = 2'd1;
  localparam logic [1:0] ADDR_CAUSE = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  // Position of the "in service" flag inside CAUSE
  localparam int CAUSE_VALID_BIT = 31;

  // Arbitration FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc
// Combinational priority encoder, lowest index wins.
// Ports:
//   vec : request vector
//   any : at least one bit of vec is set
//   id  : index of the lowest set bit (0 when vec is all zero)
module int_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    vec,
  output logic            any,
  output logic [ID_W-1:0] id
);

  // Scan from the top down so the last hit, i.e. the lowest index, sticks.
  always_comb begin
    any = |vec;
    id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// int_arbiter
// Multi-source interrupt controller feeding a single CPU interrupt line.
// Raw interrupt lines are synchronised, their rising edges latched as
// pending bits, qualified by a mask and a global enable, and the lowest
// eligible index is presented to the CPU. One interrupt is in service at
// a time; the CPU handshakes with int_ack (accept) and eret (return).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   irq_in              : raw interrupt levels (asynchronous to clk)
//   cfg_we/addr/wdata   : config register write port
//   cfg_rdata           : config read data, combinational on cfg_addr
//   int_req, int_id     : request to CPU and the requested/in-service id
//   int_ack, eret       : CPU accept and return-from-handler pulses
//   int_busy            : high while a source is in service
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              int_req,
  output logic [ID_W-1:0]   int_id,
  input  logic              int_ack,
  input  logic              eret,
  output logic              int_busy
);

  logic [N_SRC-1:0] s1_reg, s2_reg, s3_reg;
  logic [N_SRC-1:0] pend_reg, pend_next;
  logic [N_SRC-1:0] mask_reg, mask_next;
  logic             gen_reg, gen_next;
  state_t           state_reg, state_next;
  logic [ID_W-1:0]  id_reg, id_next;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] w1c_clr;
  logic [N_SRC-1:0] ack_clr;
  logic             ack_take;
  logic             any_elig;
  logic [ID_W-1:0]  sel_id;

  // --------------------------------------------------------------------
  // Synchroniser (s1, s2) plus history flop (s3) for edge detection.
  // s3 resets to 0, so a line already high at reset release yields one edge.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
      s3_reg <= '0;
    end else begin
      s1_reg <= irq_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;

  // Selection only ever looks at registered state, so a cfg write is seen
  // by the arbiter one cycle after the write edge.
  assign elig = pend_reg & mask_reg & {N_SRC{gen_reg}};

  int_prio_enc #(
    .N    (N_SRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .vec (elig),
    .any (any_elig),
    .id  (sel_id)
  );

  // --------------------------------------------------------------------
  // Config write decode
  // --------------------------------------------------------------------
  always_comb begin
    mask_next = mask_reg;
    gen_next  = gen_reg;
    w1c_clr   = '0;
    if (cfg_we) begin
      case (cfg_addr)
        ADDR_MASK: mask_next = cfg_wdata[N_SRC-1:0];
        ADDR_PEND: w1c_clr   = cfg_wdata[N_SRC-1:0];
        ADDR_CTRL: gen_next  = cfg_wdata[0];
        default:   ;
      endcase
    end
  end

  // --------------------------------------------------------------------
  // Arbitration FSM, next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    ack_take   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_elig) begin
          state_next = REQ;
          id_next    = sel_id;
        end
      end
      REQ: begin
        // Ack beats a simultaneous withdrawal; no preemption by a
        // higher-priority arrival while the request is outstanding.
        if (int_ack) begin
          ack_take   = 1'b1;
          state_next = SERVICE;
        end else if (!elig[id_reg]) begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (eret) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack_clr = '0;
    if (ack_take) ack_clr[id_reg] = 1'b1;
  end

  // Clears are applied first and the new edge is OR-ed in last, so a rise
  // on the same cycle as a W1C or ack clear keeps the bit pending.
  assign pend_next = (pend_reg & ~w1c_clr & ~ack_clr) | rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      pend_reg  <= '0;
      mask_reg  <= '0;
      gen_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
      pend_reg  <= pend_next;
      mask_reg  <= mask_next;
      gen_reg   <= gen_next;
    end
  end

  // Both flags decode straight from the state register, so they are glitch-free.
  assign int_req  = (state_reg == REQ);
  assign int_busy = (state_reg == SERVICE);
  assign int_id   = id_reg;

  // --------------------------------------------------------------------
  // Config read mux; CAUSE is only populated while in service.
  // --------------------------------------------------------------------
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK: cfg_rdata[N_SRC-1:0] = mask_reg;
      ADDR_PEND: cfg_rdata[N_SRC-1:0] = pend_reg;
      ADDR_CAUSE: begin
        if (int_busy) begin
          cfg_rdata[CAUSE_VALID_BIT] = 1'b1;
          cfg_rdata[ID_W-1:0]        = id_reg;
        end
      end
      ADDR_CTRL: cfg_rdata[0] = gen_reg;
      default:   ;
    endcase
  end

  // Write data above the source count has no destination.
  generate
    if (N_SRC < 32) begin : g_wdata_tail
      logic unused_wdata;
      assign unused_wdata = ^cfg_wdata[31:N_SRC];
    end
  endgenerate

endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference model of the arbiter.
module tb_int_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        int_req;
  logic [2:0]  int_id;
  logic        int_ack;
  logic        eret;
  logic        int_busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_cycle  = 0;

  always #5 clk = ~clk;

  int_arbiter #(.N_SRC(8), .ID_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .int_req   (int_req),
    .int_id    (int_id),
    .int_ack   (int_ack),
    .eret      (eret),
    .int_busy  (int_busy)
  );

  // ---------------- reference model ----------------
  logic [7:0] m_pend, m_mask;
  logic       m_gen;
  logic       m_req, m_svc;     // request outstanding / handler running
  logic [2:0] m_id;
  logic [7:0] m_hist [3];       // irq samples from the last three edges

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_gen = 1'b0;
    m_req = 1'b0; m_svc = 1'b0; m_id = '0;
    for (int k = 0; k < 3; k++) m_hist[k] = '0;
  endtask

  // One clock edge worth of behaviour, using the inputs currently driven.
  task automatic model_step();
    logic [7:0] rise, elig, clr;
    rise = m_hist[1] & ~m_hist[2];
    elig = m_pend & m_mask & {8{m_gen}};
    clr  = '0;
    if (cfg_we && cfg_addr == 2'd1) clr = clr | cfg_wdata[7:0];
    if (m_req) begin
      if (int_ack) begin
        clr   = clr | (8'h01 << m_id);
        m_req = 1'b0;
        m_svc = 1'b1;
        $display("txn cycle %0d: source %0d taken into service", n_cycle, m_id);
      end else if (!elig[m_id]) begin
        m_req = 1'b0;
      end
    end else if (m_svc) begin
      if (eret) m_svc = 1'b0;
    end else if (elig != 0) begin
      m_req = 1'b1;
      for (int i = 7; i >= 0; i--) if (elig[i]) m_id = i[2:0];
    end
    m_pend = (m_pend & ~clr) | rise;
    if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[7:0];
    if (cfg_we && cfg_addr == 2'd3) m_gen  = cfg_wdata[0];
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = irq_in;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[7:0] = m_mask;
      2'd1: r[7:0] = m_pend;
      2'd2: if (m_svc) r = {1'b1, 28'd0, m_id};
      default: r[0] = m_gen;
    endcase
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, n_cycle);
    end
  endtask

  task automatic compare_all();
    check_val("int_req", {31'd0, int_req}, {31'd0, m_req});
    check_val("int_busy", {31'd0, int_busy}, {31'd0, m_svc});
    if (m_req || m_svc) check_val("int_id", {29'd0, int_id}, {29'd0, m_id});
    check_val("cfg_rdata", cfg_rdata, model_rd(cfg_addr));
  endtask

  // Inputs are applied at the falling edge; pulses last one cycle.
  task automatic step();
    @(posedge clk);
    n_cycle++;
    model_step();
    @(negedge clk);
    compare_all();
    cfg_we  = 1'b0;
    int_ack = 1'b0;
    eret    = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_wdata = '0; int_ack = 1'b0; eret = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_int_req", {31'd0, int_req}, 32'd0);
    check_val("rst_int_id", {29'd0, int_id}, 32'd0);
    check_val("rst_int_busy", {31'd0, int_busy}, 32'd0);
    reset = 1'b0;

    // 1: single source, full timing of the handshake
    wr(2'd0, 32'h0000_00FF);
    wr(2'd3, 32'h0000_0001);
    irq_in = 8'h20; cfg_addr = 2'd1;
    steps(3);
    check_val("s1_pend", cfg_rdata, 32'h20);
    check_val("s1_noreq_yet", {31'd0, int_req}, 32'd0);
    step();
    check_val("s1_req", {31'd0, int_req}, 32'd1);
    check_val("s1_id", {29'd0, int_id}, 32'd5);
    int_ack = 1'b1; cfg_addr = 2'd2;
    step();
    check_val("s1_cause", cfg_rdata, 32'h8000_0005);
    check_val("s1_busy", {31'd0, int_busy}, 32'd1);
    cfg_addr = 2'd1;
    step();
    check_val("s1_pend_clr", cfg_rdata, 32'h0);
    eret = 1'b1; step();
    irq_in = 8'h00; steps(3);

    // 2: simultaneous arrival, priority and post-eret gap
    irq_in = 8'h44; steps(4);
    check_val("s2_first_id", {29'd0, int_id}, 32'd2);
    int_ack = 1'b1; step();
    eret = 1'b1; step();
    check_val("s2_gap", {31'd0, int_req}, 32'd0);
    step();
    check_val("s2_second_req", {31'd0, int_req}, 32'd1);
    check_val("s2_second_id", {29'd0, int_id}, 32'd6);
    int_ack = 1'b1; step();
    eret = 1'b1; step();
    irq_in = 8'h00; steps(3);

    // 3: withdrawal by masking, then re-request
    irq_in = 8'h08; steps(4);
    wr(2'd0, 32'h0000_00F7);
    cfg_addr = 2'd1;
    step();
    check_val("s3_withdrawn", {31'd0, int_req}, 32'd0);
    check_val("s3_pend_kept", cfg_rdata, 32'h08);
    wr(2'd0, 32'h0000_00FF);
    step();
    check_val("s3_rereq_id", {29'd0, int_id}, 32'd3);
    check_val("s3_rereq", {31'd0, int_req}, 32'd1);
    int_ack = 1'b1; step();
    eret = 1'b1; step();
    irq_in = 8'h00; steps(3);

    // 4: W1C colliding with ack, ack wins
    irq_in = 8'h10; steps(4);
    int_ack = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'h10;
    step();
    cfg_addr = 2'd2; step();
    check_val("s4_cause", cfg_rdata, 32'h8000_0004);
    eret = 1'b1; step();
    irq_in = 8'h00; steps(3);

    // 5: higher priority arrives during service, no nesting
    irq_in = 8'h02; steps(4);
    int_ack = 1'b1; step();
    irq_in = 8'h03; steps(5);
    check_val("s5_no_nest", {31'd0, int_req}, 32'd0);
    eret = 1'b1; step();
    step();
    check_val("s5_next_id", {29'd0, int_id}, 32'd0);
    check_val("s5_next_req", {31'd0, int_req}, 32'd1);
    int_ack = 1'b1; step();
    eret = 1'b1; step();
    eret = 1'b1; step();
    irq_in = 8'h00; steps(3);

    // 6: reset during service, then a line held high across release
    irq_in = 8'h01; steps(4);
    int_ack = 1'b1; step();
    irq_in = 8'h0D; cfg_addr = 2'd1; steps(4);
    check_val("s6_pend", cfg_rdata, 32'h0C);
    reset = 1'b1;
    #1;
    model_reset();
    check_val("s6_rst_req", {31'd0, int_req}, 32'd0);
    check_val("s6_rst_busy", {31'd0, int_busy}, 32'd0);
    check_val("s6_rst_id", {29'd0, int_id}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr = a[1:0];
      #1;
      check_val("s6_rst_reg", cfg_rdata, 32'h0);
    end
    irq_in = 8'h80;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cfg_addr = 2'd1;
    steps(3);
    check_val("s6_once_pend", cfg_rdata, 32'h80);
    wr(2'd1, 32'h0000_0080);
    cfg_addr = 2'd1;
    steps(5);
    check_val("s6_no_repeat", cfg_rdata, 32'h0);

    // Randomized traffic
    wr(2'd0, 32'h0000_00FF);
    wr(2'd3, 32'h0000_0001);
    for (int c = 0; c < 3000; c++) begin
      irq_in    = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      cfg_we    = ($urandom_range(0, 4) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = $urandom;
      if (cfg_addr == 2'd3 && $urandom_range(0, 3) != 0) cfg_wdata[0] = 1'b1;
      if (cfg_addr == 2'd0 && $urandom_range(0, 1) == 1) cfg_wdata[7:0] = 8'hFF;
      int_ack   = ($urandom_range(0, 2) == 0);
      eret      = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
